// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - parametrised output-stationary systolic matrix-multiply engine
// Skewed row/column operand feed into a DIM x DIM MAC array, serial row-major result drain.
module systolic_mm_engine #(
    parameter int DIM          = 4,
    parameter int INPUT_WIDTH  = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int RESULT_WIDTH = 16,
    parameter int FRAC_WIDTH   = 8,
    parameter int K_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         sat_en,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIM*INPUT_WIDTH-1:0]   row_data,
    input  logic [DIM*INPUT_WIDTH-1:0]   col_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RESULT_WIDTH-1:0]      out_data,
    output logic [$clog2(DIM)-1:0]       out_row,
    output logic [$clog2(DIM)-1:0]       out_col,
    output logic                         out_last,
    output logic                         done,
    output logic                         err_ovf
);
    localparam int IW    = INPUT_WIDTH;
    localparam int IDX_W = $clog2(DIM);
    localparam int FL_W  = $clog2(2 * DIM);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(2 * DIM - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [K_WIDTH-1:0] k_reg, k_cnt;
    logic               sat_reg;
    logic [FL_W-1:0]    fl_cnt;
    logic               beat, last_beat, out_hs, drain_end, res_ovf;

    logic [IW-1:0] a_sk [DIM][DIM-1];
    logic [IW-1:0] b_sk [DIM][DIM-1];
    logic          t_sk [DIM][DIM-1];
    logic [IW-1:0] a_tap [DIM];
    logic [IW-1:0] b_tap [DIM];
    logic          t_tap [DIM];
    logic [IW-1:0] a_pe [DIM][DIM];
    logic [IW-1:0] b_pe [DIM][DIM];
    logic          t_pe [DIM][DIM];
    logic signed [ACC_WIDTH-1:0] acc [DIM][DIM];
    logic signed [ACC_WIDTH-1:0] acc_sel, shifted;
    logic res_hi, res_lo;

    assign beat      = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_beat = beat && (k_cnt == k_reg - 1'b1);
    assign drain_end = (out_row == IDX_LAST) && (out_col == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (k_len == '0) ? DRAIN : FEED;
            FEED:    if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (fl_cnt == FL_LAST) state_nxt = DRAIN;
            DRAIN:   if (out_hs && drain_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == FEED);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && drain_end;
    end

    // Row/col g is delayed g cycles so both operands of a beat meet at PE(i,j) after i+j cycles.
    for (genvar g = 0; g < DIM; g++) begin : g_tap
        if (g == 0) begin : g_direct
            assign a_tap[g] = row_data[g*IW +: IW];
            assign b_tap[g] = col_data[g*IW +: IW];
            assign t_tap[g] = beat;
        end else begin : g_skew
            assign a_tap[g] = a_sk[g][g-1];
            assign b_tap[g] = b_sk[g][g-1];
            assign t_tap[g] = t_sk[g][g-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM-1; k++) begin
                    a_sk[i][k] <= '0;
                    b_sk[i][k] <= '0;
                    t_sk[i][k] <= 1'b0;
                end
                for (int j = 0; j < DIM; j++) begin
                    a_pe[i][j] <= '0;
                    b_pe[i][j] <= '0;
                    t_pe[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                a_sk[i][0] <= row_data[i*IW +: IW];
                b_sk[i][0] <= col_data[i*IW +: IW];
                t_sk[i][0] <= beat;
                for (int k = 1; k < DIM-1; k++) begin
                    a_sk[i][k] <= a_sk[i][k-1];
                    b_sk[i][k] <= b_sk[i][k-1];
                    t_sk[i][k] <= t_sk[i][k-1];
                end
                a_pe[i][0] <= a_tap[i];
                t_pe[i][0] <= t_tap[i];
                b_pe[0][i] <= b_tap[i];
                for (int j = 1; j < DIM; j++) begin
                    a_pe[i][j] <= a_pe[i][j-1];
                    t_pe[i][j] <= t_pe[i][j-1];
                    b_pe[j][i] <= b_pe[j-1][i];
                end
            end
        end
    end

    // The valid tag travels with the A operand; bubbles (tag 0) leave the accumulator untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    acc[i][j] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    acc[i][j] <= '0;
        end else begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    if (t_pe[i][j])
                        acc[i][j] <= acc[i][j] + ($signed(a_pe[i][j]) * $signed(b_pe[i][j]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_reg   <= '0;
            k_cnt   <= '0;
            sat_reg <= 1'b0;
            fl_cnt  <= '0;
            out_row <= '0;
            out_col <= '0;
            err_ovf <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= out_hs && drain_end;
            case (state)
                IDLE: if (start) begin
                    k_reg   <= k_len;
                    sat_reg <= sat_en;
                    k_cnt   <= '0;
                    fl_cnt  <= '0;
                    out_row <= '0;
                    out_col <= '0;
                    err_ovf <= 1'b0;
                end
                FEED:  if (beat) k_cnt <= k_cnt + 1'b1;
                FLUSH: fl_cnt <= fl_cnt + 1'b1;
                DRAIN: begin
                    if (res_ovf) err_ovf <= 1'b1;
                    if (out_hs) begin
                        if (drain_end) begin
                            out_row <= '0;
                            out_col <= '0;
                        end else if (out_col == IDX_LAST) begin
                            out_col <= '0;
                            out_row <= out_row + 1'b1;
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_sel  = acc[out_row][out_col];
        shifted  = acc_sel >>> FRAC_WIDTH;
        res_hi   = shifted > RES_MAX;
        res_lo   = shifted < RES_MIN;
        res_ovf  = (state == DRAIN) && (res_hi || res_lo);
        out_data = '0;
        if (state == DRAIN) begin
            if (sat_reg && res_hi)      out_data = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
            else if (sat_reg && res_lo) out_data = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
            else                        out_data = shifted[RESULT_WIDTH-1:0];
        end
    end
endmodule
